// File: rtl/machina_pkg.sv
// -----------------------------------------------------------------------------
// machina_pkg
//   Shared sizing helpers for the multiply_arbiter slice.
//   - tag_width : bits needed to name one of N requester ports
//   - ptr_width : bits needed to address one of DEPTH tag FIFO slots
//   - opa_lsb / opb_lsb : bit offsets of operand a / b of port i inside the
//     packed s_dat bus ({b, a} per port, 2*W bits per port)
// -----------------------------------------------------------------------------
package machina_pkg;

    function automatic int tag_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int opa_lsb(input int port, input int w);
        return port * 2 * w;
    endfunction

    function automatic int opb_lsb(input int port, input int w);
        return port * 2 * w + w;
    endfunction

endpackage

// File: rtl/multiply.sv
// -----------------------------------------------------------------------------
// multiply
//   Two-register elastic signed fixed-point multiplier.
//   Stage 1 holds operands, stage 2 holds the product (a*b) >>> Q truncated to
//   2*W bits. An accepted operand pair appears on m_stb two cycles after the
//   accepting cycle; full throughput when m_rdy stays high.
// Ports
//   clk   in  1    rising-edge clock
//   rst   in  1    synchronous reset, active-high (clears valid bits only)
//   s_stb in  1    operand strobe          s_rdy out 1   operand ready
//   s_a   in  W    signed operand a        s_b   in  W   signed operand b
//   m_stb out 1    product strobe          m_rdy in  1   product ready
//   m_dat out 2*W  product
// -----------------------------------------------------------------------------
module multiply #(
    parameter int W = 8,
    parameter int Q = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           s_stb,
    output logic           s_rdy,
    input  logic [W-1:0]   s_a,
    input  logic [W-1:0]   s_b,
    output logic           m_stb,
    input  logic           m_rdy,
    output logic [2*W-1:0] m_dat
);

    logic                  v1_q, v1_d, v2_q, v2_d;
    logic signed [W-1:0]   a1_q, a1_d, b1_q, b1_d;
    logic [2*W-1:0]        p2_q, p2_d;
    logic                  adv1, adv2;
    logic signed [2*W-1:0] prod_full;

    always_comb begin
        adv2      = ~v2_q | m_rdy;
        adv1      = ~v1_q | adv2;
        // The full signed product of two W-bit values always fits in 2*W bits.
        prod_full = (2*W)'(a1_q) * (2*W)'(b1_q);
        v1_d      = v1_q;
        a1_d      = a1_q;
        b1_d      = b1_q;
        v2_d      = v2_q;
        p2_d      = p2_q;
        if (adv1) begin
            v1_d = s_stb;
            a1_d = s_a;
            b1_d = s_b;
        end
        if (adv2) begin
            v2_d = v1_q;
            p2_d = prod_full >>> Q;
        end
    end

    assign s_rdy = adv1;
    assign m_stb = v2_q;
    assign m_dat = p2_q;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            v1_q <= 1'b0;
            v2_q <= 1'b0;
        end else begin
            v1_q <= v1_d;
            v2_q <= v2_d;
        end
    end

    // NOTE: data registers carry no reset; their contents are ignored while the
    // matching valid bit is low, so clearing them buys nothing.
    always_ff @(posedge clk) begin
        a1_q <= a1_d;
        b1_q <= b1_d;
        p2_q <= p2_d;
    end

endmodule

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational request arbiter: picks the first requester at or after the
//   round-robin pointer, wrapping cyclically.
//   Build option MULTIPLY_ARBITER_FIXED_PRIO_EN: lowest index always wins and
//   the pointer input disappears.
// Ports
//   req     in  N   request vector
//   ptr     in  TW  round-robin start index (round-robin build only)
//   gnt     out N   one-hot grant, zero when no request
//   gnt_idx out TW  index of the granted requester
//   gnt_vld out 1   some requester is granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import machina_pkg::*;
#(
    parameter int N  = 4,
    parameter int TW = tag_width(N)
) (
    input  logic [N-1:0]  req,
`ifndef MULTIPLY_ARBITER_FIXED_PRIO_EN
    input  logic [TW-1:0] ptr,
`endif
    output logic [N-1:0]  gnt,
    output logic [TW-1:0] gnt_idx,
    output logic          gnt_vld
);

    always_comb begin
        // NOTE: every output gets a default before any condition, so no path
        // through this block can leave a signal unassigned and infer a latch.
        gnt_idx = '0;
        gnt_vld = 1'b0;
`ifdef MULTIPLY_ARBITER_FIXED_PRIO_EN
        // Scan high to low so the lowest requesting index is the last writer.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[k]) begin
                gnt_idx = TW'(k);
                gnt_vld = 1'b1;
            end
        end
`else
        // Scan offsets high to low so the smallest offset from ptr wins.
        for (int k = N - 1; k >= 0; k--) begin
            if (req[(int'(ptr) + k) % N]) begin
                gnt_idx = TW'((int'(ptr) + k) % N);
                gnt_vld = 1'b1;
            end
        end
`endif
        gnt = gnt_vld ? (N'(1) << gnt_idx) : '0;
    end

endmodule

// File: rtl/multiply_arbiter.sv
// -----------------------------------------------------------------------------
// multiply_arbiter
//   Shares one `multiply` datapath among N requesters. Operand side is
//   round-robin arbitrated; every grant pushes the winner's index into a tag
//   FIFO so each product returns, in issue order, to the port that sent it.
//   Build option MULTIPLY_ARBITER_FIXED_PRIO_EN: fixed priority (lowest index
//   wins), round-robin pointer removed. Return path identical in both builds.
// Ports
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous reset, active-low
//   s_stb in  N      operand strobe per port
//   s_dat in  N*2*W  port i operands at [i*2W +: 2W] = {b, a}, signed
//   s_rdy out N      operand ready; only the granted bit can be set
//   m_stb out N      result strobe, one-hot or zero
//   m_dat out 2*W    product, valid for the port whose m_stb bit is set
//   m_rdy in  N      result ready per port
// -----------------------------------------------------------------------------
module multiply_arbiter
    import machina_pkg::*;
#(
    parameter int N     = 4,
    parameter int W     = 8,
    parameter int Q     = 0,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     s_stb,
    input  logic [N*2*W-1:0] s_dat,
    output logic [N-1:0]     s_rdy,
    output logic [N-1:0]     m_stb,
    output logic [2*W-1:0]   m_dat,
    input  logic [N-1:0]     m_rdy
);

    localparam int          TW       = tag_width(N);
    localparam int          PW       = ptr_width(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    logic [N-1:0]   gnt;
    logic [TW-1:0]  gnt_idx;
    logic           gnt_vld;

    logic           mul_rst, mul_s_stb, mul_s_rdy, mul_m_stb, mul_m_rdy;
    logic [W-1:0]   mul_a, mul_b;
    logic [2*W-1:0] mul_m_dat;

    logic [TW-1:0]  tag_mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic [TW-1:0]  head;
    logic           fifo_full, fifo_empty, push, pop;
`ifndef MULTIPLY_ARBITER_FIXED_PRIO_EN
    logic [TW-1:0]  ptr_q, ptr_d;
`endif

    rr_arbiter #(.N(N), .TW(TW)) u_arb (
        .req     (s_stb),
`ifndef MULTIPLY_ARBITER_FIXED_PRIO_EN
        .ptr     (ptr_q),
`endif
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_vld (gnt_vld)
    );

    always_comb begin
        fifo_full  = (count_q == FULL_CNT);
        fifo_empty = (count_q == '0);
        head       = tag_mem_q[rd_ptr_q];
        // A grant exists only for a strobing port, so push is the handshake.
        // Holding rst low also blocks issue: nothing is accepted to be dropped.
        push       = gnt_vld & mul_s_rdy & ~fifo_full & rst;
        s_rdy      = push ? gnt : '0;
        mul_s_stb  = push;
        mul_a      = s_dat[opa_lsb(int'(gnt_idx), W) +: W];
        mul_b      = s_dat[opb_lsb(int'(gnt_idx), W) +: W];
        // Head port's ready back-pressures the multiplier; the empty guard keeps
        // a stale head tag from ever being used as an index.
        mul_m_rdy  = ~fifo_empty & m_rdy[head];
        pop        = mul_m_stb & mul_m_rdy;
        m_stb      = mul_m_stb ? (N'(1) << head) : '0;
        m_dat      = mul_m_dat;
        wr_ptr_d   = wr_ptr_q + PW'(push);
        rd_ptr_d   = rd_ptr_q + PW'(pop);
        count_d    = count_q + (PW+1)'(push) - (PW+1)'(pop);
        mul_rst    = ~rst;
`ifndef MULTIPLY_ARBITER_FIXED_PRIO_EN
        ptr_d      = ptr_q;
        if (push) begin
            ptr_d = (gnt_idx == TW'(N - 1)) ? '0 : gnt_idx + TW'(1);
        end
`endif
    end

    multiply #(.W(W), .Q(Q)) u_mul (
        .clk   (clk),
        .rst   (mul_rst),
        .s_stb (mul_s_stb),
        .s_rdy (mul_s_rdy),
        .s_a   (mul_a),
        .s_b   (mul_b),
        .m_stb (mul_m_stb),
        .m_rdy (mul_m_rdy),
        .m_dat (mul_m_dat)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifndef MULTIPLY_ARBITER_FIXED_PRIO_EN
            ptr_q    <= '0;
`endif
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
`ifndef MULTIPLY_ARBITER_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem_q[wr_ptr_q] <= gnt_idx;
        end
    end

endmodule

// File: tb/tb_multiply_arbiter.sv
`timescale 1ns/1ps
module tb_multiply_arbiter;

    localparam int N     = 4;
    localparam int W     = 8;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     s_stb, s_rdy, m_stb, m_rdy;
    logic [N*2*W-1:0] s_dat;
    logic [2*W-1:0]   m_dat;
    logic [2*W-1:0]   ops [N];

    logic [N-1:0]     s_stb4, s_rdy4, m_stb4, m_rdy4;
    logic [N*2*W-1:0] s_dat4;
    logic [2*W-1:0]   m_dat4;

    int               checks = 0;
    int               errors = 0;

    // Reference model state: round-robin pointer and in-order result queue.
    int               ptr;
    int               exp_port [$];
    logic [2*W-1:0]   exp_prod [$];
    int               issued   [$];

    always #5 clk = ~clk;

    always_comb begin
        s_dat = '0;
        for (int i = 0; i < N; i++) s_dat[i*2*W +: 2*W] = ops[i];
    end

    multiply_arbiter #(.N(N), .W(W), .Q(0), .DEPTH(DEPTH)) u_dut (
        .clk(clk), .rst(rst), .s_stb(s_stb), .s_dat(s_dat), .s_rdy(s_rdy),
        .m_stb(m_stb), .m_dat(m_dat), .m_rdy(m_rdy)
    );

    multiply_arbiter #(.N(N), .W(W), .Q(4), .DEPTH(DEPTH)) u_dut_q4 (
        .clk(clk), .rst(rst), .s_stb(s_stb4), .s_dat(s_dat4), .s_rdy(s_rdy4),
        .m_stb(m_stb4), .m_dat(m_dat4), .m_rdy(m_rdy4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [N-1:0] onehot(input int g);
        logic [N-1:0] r;
        r    = '0;
        r[g] = 1'b1;
        return r;
    endfunction

    // First strobing port at or after p, cyclically (or lowest index).
    function automatic int model_grant(input logic [N-1:0] req, input int p);
`ifdef MULTIPLY_ARBITER_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (req[i]) return i;
`else
        for (int k = 0; k < N; k++) if (req[(p + k) % N]) return (p + k) % N;
`endif
        return -1;
    endfunction

    function automatic logic [2*W-1:0] ref_product(input logic [2*W-1:0] op, input int q);
        int a, b, p;
        a = int'($signed(op[W-1:0]));
        b = int'($signed(op[2*W-1:W]));
        p = (a * b) >>> q;
        return p[2*W-1:0];
    endfunction

    // One clock of the Q=0 DUT: check outputs mid-cycle, then advance model.
    task automatic step();
        int g;
        @(negedge clk);
        g = model_grant(s_stb, ptr);
        if (!rst || g < 0 || exp_port.size() >= DEPTH)
            check("s_rdy_idle", 32'(s_rdy), 32'(0));
        else if (m_rdy == '1 || s_rdy != '0)
            check("s_rdy_grant", 32'(s_rdy), 32'(onehot(g)));
        if (exp_port.size() == 0) begin
            check("m_stb_idle", 32'(m_stb), 32'(0));
        end else if (m_stb != '0) begin
            check("m_stb_port", 32'(m_stb), 32'(onehot(exp_port[0])));
            check("m_dat", 32'(m_dat), 32'(exp_prod[0]));
        end
        if (m_stb != '0 && exp_port.size() > 0 && m_rdy[exp_port[0]]) begin
            void'(exp_port.pop_front());
            void'(exp_prod.pop_front());
        end
        if (rst && g >= 0 && s_rdy[g]) begin
            exp_port.push_back(g);
            exp_prod.push_back(ref_product(ops[g], 0));
            issued.push_back(g);
            ptr = (g + 1) % N;
        end
        if (!rst) begin
            exp_port.delete();
            exp_prod.delete();
            ptr = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic randomize_ops();
        for (int i = 0; i < N; i++) ops[i] = 16'($urandom);
    endtask

    task automatic drain(input string tag);
        s_stb = '0;
        m_rdy = '1;
        for (int c = 0; c < 40 && exp_port.size() > 0; c++) step();
        check(tag, 32'(exp_port.size()), 32'(0));
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    logic [2*W-1:0] t4_ops [3];
    logic [2*W-1:0] t4_exp [3];
    logic [2*W-1:0] held;

    initial begin
        rst    = 1'b0;
        s_stb  = '0;
        m_rdy  = '1;
        s_stb4 = '0;
        s_dat4 = '0;
        m_rdy4 = '1;
        ptr    = 0;
        for (int i = 0; i < N; i++) ops[i] = '0;
        @(posedge clk);
        #1;

        // Reset with every port strobing: nothing may be accepted.
        s_stb = '1;
        step();
        step();
        s_stb = '0;
        rst   = 1'b1;
        #1;
        check("rst_s_rdy", 32'(s_rdy), 32'(0));
        check("rst_m_stb", 32'(m_stb), 32'(0));

        // Single port, a=3 b=-4: product -12 two cycles after accepting cycle.
        ops[0] = {8'hFC, 8'h03};
        s_stb  = 4'b0001;
        #1;
        check("t1_accept", 32'(s_rdy), 32'(4'b0001));
        step();
        s_stb = '0;
        #1;
        check("t1_lat1", 32'(m_stb), 32'(0));
        step();
        check("t1_m_stb", 32'(m_stb), 32'(4'b0001));
        check("t1_m_dat", 32'(m_dat), 32'(16'hFFF4));
        step();
        check("t1_popped", 32'(m_stb), 32'(0));

        // Q=4 instance: fixed-point scaling and sign handling.
        t4_ops[0] = 16'h1820; t4_exp[0] = 16'h0030;
        t4_ops[1] = 16'h18E0; t4_exp[1] = 16'hFFD0;
        t4_ops[2] = 16'h8080; t4_exp[2] = 16'h0400;
        for (int k = 0; k < 3; k++) begin
            s_dat4[2*W-1:0] = t4_ops[k];
            s_stb4 = 4'b0001;
            #1;
            check("t4_accept", 32'(s_rdy4), 32'(4'b0001));
            @(posedge clk); #1;
            s_stb4 = '0;
            @(posedge clk); #1;
            check("t4_m_stb", 32'(m_stb4), 32'(4'b0001));
            check("t4_m_dat", 32'(m_dat4), 32'(t4_exp[k]));
            @(posedge clk); #1;
            check("t4_popped", 32'(m_stb4), 32'(0));
        end

        // All ports strobe for 8 cycles from pointer 0.
        reset_pulse();
        issued.delete();
        s_stb = '1;
        for (int c = 0; c < 8; c++) begin
            randomize_ops();
            step();
        end
        check("t2_count", 32'(issued.size()), 32'(8));
        for (int i = 0; i < issued.size(); i++) begin
`ifdef MULTIPLY_ARBITER_FIXED_PRIO_EN
            check("t2_order", 32'(issued[i]), 32'(0));
`else
            check("t2_order", 32'(issued[i]), 32'(i % N));
`endif
        end
        drain("t2_drain");

        // Port 1 result stalled at head: result held, issue stops.
        s_stb = 4'b1110;
        m_rdy = 4'b1101;
        randomize_ops();
        for (int c = 0; c < 10; c++) step();
        held = ref_product(ops[1], 0);
        for (int c = 0; c < 3; c++) begin
            check("t3_s_rdy", 32'(s_rdy), 32'(0));
            check("t3_m_stb", 32'(m_stb), 32'(4'b0010));
            check("t3_m_dat", 32'(m_dat), 32'(held));
            step();
        end
        drain("t3_drain");

        // Reset with products in flight: they vanish, new traffic is clean.
        s_stb = '1;
        m_rdy = '0;
        randomize_ops();
        for (int c = 0; c < 3; c++) step();
        rst = 1'b0;
        step();
        check("t5_m_stb", 32'(m_stb), 32'(0));
        check("t5_s_rdy", 32'(s_rdy), 32'(0));
        rst   = 1'b1;
        m_rdy = '1;
        s_stb = 4'b0100;
        randomize_ops();
        step();
        s_stb = '0;
        step();
        check("t5_new_port", 32'(m_stb), 32'(4'b0100));
        check("t5_new_dat", 32'(m_dat), 32'(ref_product(ops[2], 0)));
        drain("t5_drain");

        // Ports 0 and 2 strobe continuously.
        reset_pulse();
        issued.delete();
        s_stb = 4'b0101;
        for (int c = 0; c < 8; c++) begin
            randomize_ops();
            step();
        end
        for (int i = 0; i < issued.size(); i++) begin
`ifdef MULTIPLY_ARBITER_FIXED_PRIO_EN
            check("t6_order", 32'(issued[i]), 32'(0));
`else
            check("t6_order", 32'(issued[i]), 32'((i % 2) * 2));
`endif
        end
        drain("t6_drain");

        // Random traffic with random back-pressure against the model.
        for (int c = 0; c < 400; c++) begin
            s_stb = N'($urandom);
            m_rdy = ($urandom_range(0, 3) == 0) ? N'($urandom) : '1;
            randomize_ops();
            step();
        end
        drain("rand_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
